// File: rtl/writeback_unit.sv
// Retires ALU results and load data into the 16x16 register file via a one-hot write bus.
// ALU write one cycle after accept; load write one cycle after the memory data returns.
// ex_ready is high only in IDLE, so a load stalls execute until its data returns or is dropped.
module writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_we,
  input  logic [3:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic [15:0] ex_result,
  input  logic [15:0] ex_addr,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic [15:0] r,
  output logic [15:0] en,
  output logic [15:0] pending
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t      state;
  logic [3:0]  rd_q;
  logic        we_q;
  logic [15:0] ex_mask;
  logic [15:0] ld_mask;
  logic        accept;

  assign ex_mask  = ex_we ? (16'h0001 << ex_rd) : 16'h0000;
  assign ld_mask  = we_q ? (16'h0001 << rd_q) : 16'h0000;
  assign ex_ready = rst && (state == IDLE);
  assign accept   = ex_valid && ex_ready;

  // Writeback FSM: en is a one-cycle pulse, pending tracks the single outstanding write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      r        <= '0;
      en       <= '0;
      pending  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      en <= '0;
      case (state)
        IDLE: begin
          // Clearing here retires the bit of an ALU write whose en pulse is on the bus now.
          pending <= '0;
          if (accept) begin
            pending <= ex_mask;
            if (!ex_is_load) begin
              r  <= ex_result;
              en <= ex_mask;
            end else begin
              rd_q     <= ex_rd;
              we_q     <= ex_we;
              mem_addr <= ex_addr;
              mem_req  <= 1'b1;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_rvalid) begin
              // Zero-latency memory: grant and data in the same cycle.
              if (!flush) begin
                r  <= mem_rdata;
                en <= ld_mask;
              end
              pending <= '0;
              state   <= IDLE;
            end else if (flush) begin
              pending <= '0;
              state   <= DRAIN;
            end else begin
              state <= WAIT;
            end
          end else if (flush) begin
            // Never granted, so nothing will come back: just withdraw the request.
            mem_req <= 1'b0;
            pending <= '0;
            state   <= IDLE;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (!flush) begin
              r  <= mem_rdata;
              en <= ld_mask;
            end
            pending <= '0;
            state   <= IDLE;
          end else if (flush) begin
            pending <= '0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          // The granted read still returns; swallow it before accepting new work.
          if (mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed cases followed by randomized ALU/load traffic.
// Expected bus values are derived per cycle from the instruction-level latency rules.
// The bench plays the memory, so grant/data timing and flushes are chosen by the stimulus.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_we;
  logic [3:0]  ex_rd;
  logic        ex_is_load;
  logic [15:0] ex_result;
  logic [15:0] ex_addr;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [15:0] r;
  logic [15:0] en;
  logic [15:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectations for the cycle following the next rising edge.
  logic [15:0] exp_en, exp_r, exp_pend, exp_addr;
  logic        exp_rchk, exp_ready, exp_req;

  writeback_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_we      (ex_we),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_result  (ex_result),
    .ex_addr    (ex_addr),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .r          (r),
    .en         (en),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_defaults();
    exp_en    = 16'h0;
    exp_r     = 16'h0;
    exp_rchk  = 1'b0;
    exp_pend  = 16'h0;
    exp_ready = 1'b1;
    exp_req   = 1'b0;
    exp_addr  = 16'h0;
  endtask

  // Advance one cycle, then compare every observable output against expectations.
  task automatic step();
    @(posedge clk);
    #1;
    chk("en", en, exp_en);
    if (exp_rchk) chk("r", r, exp_r);
    chk("pending", pending, exp_pend);
    chk("ex_ready", {15'h0, ex_ready}, {15'h0, exp_ready});
    chk("mem_req", {15'h0, mem_req}, {15'h0, exp_req});
    if (exp_req) chk("mem_addr", mem_addr, exp_addr);
    set_defaults();
  endtask

  // Junk on the execute side while the unit is busy must be ignored.
  task automatic noise();
    ex_valid   = 1'($urandom_range(1));
    ex_is_load = 1'($urandom_range(1));
    ex_we      = 1'($urandom_range(1));
    ex_rd      = 4'($urandom);
    ex_result  = 16'($urandom);
    ex_addr    = 16'($urandom);
  endtask

  task automatic quiet();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    flush      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  function automatic logic [15:0] onehot(input logic [3:0] rd, input logic we);
    return we ? (16'h0001 << rd) : 16'h0000;
  endfunction

  // ALU op: write visible the next cycle; flush and stray rvalid in IDLE have no effect.
  task automatic do_alu(input logic [3:0] rd, input logic we, input logic [15:0] res);
    ex_valid   = 1'b1;
    ex_is_load = 1'b0;
    ex_we      = we;
    ex_rd      = rd;
    ex_result  = res;
    ex_addr    = 16'($urandom);
    flush      = 1'($urandom_range(1));
    mem_rvalid = 1'($urandom_range(1));
    mem_rdata  = 16'($urandom);
    exp_en     = onehot(rd, we);
    exp_r      = res;
    exp_rchk   = 1'b1;
    exp_pend   = onehot(rd, we);
    exp_ready  = 1'b1;
    step();
    quiet();
  endtask

  // Load: gd request cycles without grant, then grant; data dd cycles after grant.
  // fm: 0 none, 1 flush before grant, 2 flush in WAIT (or earliest later point), 3 flush with data.
  task automatic do_load(input logic [3:0] rd, input logic we, input logic [15:0] addr,
                         input int gd, input int dd, input int fm, input logic [15:0] data);
    logic [15:0] m;
    logic        dropped;
    m = onehot(rd, we);
    dropped = 1'b0;
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_we      = we;
    ex_rd      = rd;
    ex_addr    = addr;
    ex_result  = 16'($urandom);
    exp_req    = 1'b1;
    exp_addr   = addr;
    exp_pend   = m;
    exp_ready  = 1'b0;
    step();
    quiet();
    if (fm == 1) begin
      noise();
      flush     = 1'b1;
      exp_pend  = 16'h0;
      exp_ready = 1'b1;
      step();
      quiet();
      return;
    end
    for (int i = 0; i < gd; i++) begin
      noise();
      mem_rvalid = 1'($urandom_range(1));
      mem_rdata  = 16'($urandom);
      exp_req    = 1'b1;
      exp_addr   = addr;
      exp_pend   = m;
      exp_ready  = 1'b0;
      step();
    end
    mem_rvalid = 1'b0;
    noise();
    mem_gnt = 1'b1;
    if (dd == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      flush      = (fm >= 2);
      exp_ready  = 1'b1;
      if (fm == 0) begin
        exp_en   = m;
        exp_r    = data;
        exp_rchk = 1'b1;
      end
      step();
    end else begin
      flush     = (fm == 2 && dd == 1);
      dropped   = flush;
      exp_pend  = dropped ? 16'h0 : m;
      exp_ready = 1'b0;
      step();
      mem_gnt = 1'b0;
      flush   = 1'b0;
      for (int i = 0; i < dd - 1; i++) begin
        noise();
        flush = (fm == 2 && i == 0);
        if (flush) dropped = 1'b1;
        exp_pend  = dropped ? 16'h0 : m;
        exp_ready = 1'b0;
        step();
        flush = 1'b0;
      end
      noise();
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      flush      = (fm == 3);
      exp_ready  = 1'b1;
      if (fm == 0) begin
        exp_en   = m;
        exp_r    = data;
        exp_rchk = 1'b1;
      end
      step();
    end
    quiet();
  endtask

  initial begin
    rst        = 1'b0;
    ex_valid   = 1'b0;
    ex_we      = 1'b0;
    ex_rd      = 4'h0;
    ex_is_load = 1'b0;
    ex_result  = 16'h0;
    ex_addr    = 16'h0;
    flush      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    set_defaults();

    // Reset held for two cycles: everything zero, not ready.
    for (int i = 0; i < 2; i++) begin
      exp_ready = 1'b0;
      exp_rchk  = 1'b1;
      step();
    end
    chk("rst_mem_addr", mem_addr, 16'h0);
    rst = 1'b1;
    #1;
    chk("ready_after_rst", {15'h0, ex_ready}, 16'h0001);

    // Back-to-back ALU writes.
    do_alu(4'd3, 1'b1, 16'h1234);
    do_alu(4'd15, 1'b1, 16'hBEEF);
    step();

    // Load with grant on the second request cycle and data three cycles later.
    do_load(4'd5, 1'b1, 16'h0040, 1, 3, 0, 16'hA5A5);
    step();

    // Zero-latency memory.
    do_load(4'd7, 1'b1, 16'h1000, 0, 0, 0, 16'h0001);

    // Flush before grant, then flush in WAIT with later 0xFFFF data.
    do_load(4'd9, 1'b1, 16'h2222, 1, 2, 1, 16'h0000);
    do_load(4'd9, 1'b1, 16'h3333, 0, 3, 2, 16'hFFFF);
    step();

    // Non-writing instructions, and register 0 as an ordinary target.
    do_alu(4'd4, 1'b0, 16'h5555);
    do_load(4'd6, 1'b0, 16'h0080, 0, 1, 0, 16'h7777);
    do_alu(4'd0, 1'b1, 16'hCAFE);

    // Reset mid-load in WAIT, then a late rvalid is ignored.
    do_alu(4'd1, 1'b1, 16'h0F0F);
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_we      = 1'b1;
    ex_rd      = 4'd2;
    ex_addr    = 16'h0404;
    exp_req    = 1'b1;
    exp_addr   = 16'h0404;
    exp_pend   = 16'h0004;
    exp_ready  = 1'b0;
    step();
    quiet();
    mem_gnt   = 1'b1;
    exp_pend  = 16'h0004;
    exp_ready = 1'b0;
    step();
    mem_gnt   = 1'b0;
    rst       = 1'b0;
    exp_ready = 1'b0;
    exp_rchk  = 1'b1;
    step();
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h9999;
    exp_rchk   = 1'b1;
    step();
    quiet();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int sel, fm;
      sel = int'($urandom_range(9));
      if (sel < 3) begin
        do_alu(4'($urandom), 1'($urandom_range(1)), 16'($urandom));
      end else if (sel == 3) begin
        step();
      end else begin
        case ($urandom_range(7))
          5:       fm = 1;
          6:       fm = 2;
          7:       fm = 3;
          default: fm = 0;
        endcase
        do_load(4'($urandom), 1'($urandom_range(1)), 16'($urandom),
                int'($urandom_range(3)), int'($urandom_range(3)), fm, 16'($urandom));
      end
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Retires executed instructions into the register file, the write side that complements register fetch. It accepts one result per handshake from execute. ALU results are written back after one cycle. Loads are issued to data memory, and the returned word is written when it arrives. The block drives the register-file write bus `r` with a one-hot enable, and publishes a pending-write mask that fetch uses for RAW stalls.

## Interface
Parameters:
- none. Data is 16-bit, with 16 registers.

Ports:
- `clk` in 1: the single clock. Everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `ex_valid` in 1: execute is presenting an instruction.
- `ex_ready` out 1: the unit can accept an instruction. Equals `rst && state==IDLE`.
- `ex_we` in 1: the instruction writes a register. This is the same condition as fetch's `!(st || (jmp && !fn))`.
- `ex_rd` in 4: the destination register index.
- `ex_is_load` in 1: the instruction is a memory load.
- `ex_result` in 16: the ALU result.
- `ex_addr` in 16: the load address.
- `flush` in 1: discard the in-flight load.
- `mem_req` out 1: load request. Held high until granted.
- `mem_addr` out 16: the load address. Stable while `mem_req` is high.
- `mem_gnt` in 1: the memory has accepted the request.
- `mem_rvalid` in 1: read data is valid.
- `mem_rdata` in 16: read data.
- `r` out 16: write data to the register file.
- `en` out 16: one-hot register write enable. All zeros when not writing.
- `pending` out 16: bit i is set while a write to register i is outstanding.

## Operation
- States: IDLE, REQ, WAIT, DRAIN. Reset enters IDLE.
- Accept: `ex_valid && ex_ready` is sampled on a rising edge. Only IDLE accepts.
- ALU op (`ex_is_load`=0):
  - `r` <= `ex_result`.
  - `en` <= `ex_we ? (1<<ex_rd) : 0`.
  - State stays IDLE.
  - `en` is high for exactly one cycle.
- Load (`ex_is_load`=1):
  - Latch `ex_rd`, `ex_we` and `ex_addr` into `mem_addr`. Set `mem_req` to 1. Go to REQ.
- REQ:
  - `mem_gnt` seen → `mem_req` <= 0, go to WAIT.
  - If `mem_rvalid` is also high in that same cycle (zero-latency memory), treat it as the data return: write back and go straight to IDLE.
- WAIT:
  - `mem_rvalid` → `r` <= `mem_rdata`, `en` <= `we ? 1<<rd : 0`, go to IDLE.
- Flush handling:
  - `flush` in REQ without `mem_gnt` → drop `mem_req`, go to IDLE, no write.
  - `flush` in REQ with `mem_gnt` (and no `mem_rvalid`), or `flush` in WAIT without `mem_rvalid` → go to DRAIN.
  - DRAIN: wait for `mem_rvalid`, discard the data, go to IDLE.
  - `flush` in the same cycle as `mem_rvalid` → discard the data, no write, go to IDLE.
  - `flush` in IDLE → no effect. An ALU write in progress still completes.
- `mem_rvalid` in IDLE or during a REQ cycle without grant → ignored.
- `pending`:
  - Set bit `ex_rd` on accept when `ex_we`=1.
  - Clear that bit on the edge where `en` is driven high for that register. For an ALU op the bit is therefore high only during the cycle its `en` pulses.
  - Cleared on flush or drop.
  - At most one bit is set at a time.
- Writes to register 0 are ordinary writes. There is no hardwired zero register.

## Timing
- Reset (`rst`=0 at an edge):
  - `r`=0, `en`=0, `pending`=0, `mem_req`=0, `mem_addr`=0, state=IDLE.
  - `ex_ready`=0 while `rst`=0.
- Reset during REQ, WAIT or DRAIN aborts immediately. A later `mem_rvalid` is ignored, because the unit is in IDLE.
- ALU latency: accept at edge N → `en`/`r` valid during cycle N+1. A new instruction can be accepted at edge N+1. This gives back-to-back throughput of one per cycle.
- Load latency: accept at edge N → `mem_req` high from cycle N+1.
  - Grant at edge G, data at edge D≥G → `en` is high during cycle D+1.
  - `ex_ready` is high again in cycle D+1, so a new instruction can be accepted at edge D+1 while the load's write pulse is on the bus.
- `mem_addr` holds its value after a grant until the next load accept.

## Test plan
- Reset, then check outputs:
  - Stimulus: hold `rst`=0 for 2 cycles, then set `rst`=1.
  - Response: `en`=0, `r`=0, `pending`=0, `mem_req`=0. `ex_ready` is 0 during reset and 1 on the first cycle after.
- Back-to-back ALU writes:
  - Stimulus: accept rd=3 with result 0x1234, then rd=15 with result 0xBEEF on consecutive edges.
  - Response: `en`=0x0008 with `r`=0x1234, then `en`=0x8000 with `r`=0xBEEF. `ex_ready` never drops.
- Load with 2-cycle grant and 3-cycle data:
  - Stimulus: accept rd=5, addr=0x0040.
  - Response: `mem_req` high with `mem_addr`=0x0040 until grant. `pending`=0x0020 throughout. `ex_ready`=0 until the data returns. After `mem_rdata`=0xA5A5, `en`=0x0020 and `r`=0xA5A5 for one cycle, then `pending`=0.
- Zero-latency memory:
  - Stimulus: `mem_gnt` and `mem_rvalid` both high in the first REQ cycle, with data 0x0001 and rd=7.
  - Response: a single write of 0x0001 with `en`=0x0080, and the unit returns to IDLE.
- Flush cases:
  - Flush in REQ before grant → `mem_req` drops next cycle, no write, `pending`=0.
  - Flush in WAIT → DRAIN. `mem_rvalid` with 0xFFFF later produces no `en`, then the unit returns to IDLE.
- Non-writing instructions, and reset mid-load:
  - A store or jump (`ex_we`=0) gives `en`=0 and `pending`=0.
  - Reset asserted in WAIT, followed by `mem_rvalid` → no write occurs.
